// File: rtl/qsfp_i2c_reg_pkg.sv
// Shared definitions for the QSFP I2C register bank: word offsets, CTRL/STATUS bit
// positions and the command FSM state encoding.
package qsfp_i2c_reg_pkg;

  // Word index (byte address [7:2])
  localparam logic [5:0] RegVersion = 6'h00;
  localparam logic [5:0] RegCmd     = 6'h01;
  localparam logic [5:0] RegCtrl    = 6'h02;
  localparam logic [5:0] RegStatus  = 6'h03;
  localparam logic [5:0] RegTimeout = 6'h04;
  localparam logic [5:0] RegScratch = 6'h05;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlAbortBit = 1;

  localparam int unsigned StatusBusyBit    = 0;
  localparam int unsigned StatusDoneBit    = 1;
  localparam int unsigned StatusNackBit    = 2;
  localparam int unsigned StatusTimeoutBit = 3;
  localparam int unsigned StatusOverrunBit = 4;

  localparam int unsigned TimeoutW = 24;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } fsm_state_e;

endpackage

// File: rtl/qsfp_i2c_cmd_fsm.sv
// Command sequencer: offers one command to the I2C engine, waits for its response and
// guards both phases with a shared cycle counter against a programmable timeout.
module qsfp_i2c_cmd_fsm
  import qsfp_i2c_reg_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [TimeoutW-1:0] timeout_i,
  input  logic                eng_cmd_ready_i,
  input  logic                eng_rsp_valid_i,
  output logic                busy_o,
  output logic                eng_cmd_valid_o,
  output logic                eng_abort_o,
  output logic                rsp_done_o,
  output logic                timeout_set_o,
  output logic                overrun_set_o
);

  fsm_state_e          state_q, state_d;
  logic [TimeoutW-1:0] cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic [TimeoutW:0]   cnt_inc;
  logic                expire;

  assign cnt_inc = {1'b0, cnt_q} + {{TimeoutW{1'b0}}, 1'b1};
  // A zero TIMEOUT never matches, which disables the guard.
  assign expire  = (timeout_i != '0) && (cnt_inc == {1'b0, timeout_i});

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    abort_d       = 1'b0;
    rsp_done_o    = 1'b0;
    timeout_set_o = 1'b0;
    overrun_set_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d = StIssue;
          cnt_d   = '0;
        end
      end
      StIssue: begin
        overrun_set_o = start_i && !abort_i;
        if (abort_i) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else if (eng_cmd_ready_i) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (expire) begin
          state_d       = StIdle;
          abort_d       = 1'b1;
          timeout_set_o = 1'b1;
        end else begin
          cnt_d = cnt_inc[TimeoutW-1:0];
        end
      end
      StWait: begin
        overrun_set_o = start_i && !abort_i;
        // A completing response beats both software abort and timeout.
        if (eng_rsp_valid_i) begin
          state_d    = StIdle;
          rsp_done_o = 1'b1;
        end else if (abort_i) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else if (expire) begin
          state_d       = StIdle;
          abort_d       = 1'b1;
          timeout_set_o = 1'b1;
        end else begin
          cnt_d = cnt_inc[TimeoutW-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign busy_o          = (state_q != StIdle);
  assign eng_cmd_valid_o = (state_q == StIssue);
  assign eng_abort_o     = abort_q;

endmodule

// File: rtl/qsfp_i2c_reg_bank.sv
// QSFP I2C register bank: register decode, sticky W1C status, registered read mux and the
// command sequencer that drives the I2C engine.
module qsfp_i2c_reg_bank
  import qsfp_i2c_reg_pkg::*;
#(
  parameter int unsigned   AXI_ADDR_WIDTH  = 32,
  parameter int unsigned   AXI_DATA_WIDTH  = 32,
  parameter logic [31:0]   VERSION         = 32'h0001_0000,
  parameter logic [23:0]   TIMEOUT_DEFAULT = 24'd1_000_000
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  input  logic                        wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic [AXI_DATA_WIDTH-1:0]   rdata,
  output logic                        eng_cmd_valid,
  input  logic                        eng_cmd_ready,
  output logic [6:0]                  eng_dev_addr,
  output logic                        eng_rnw,
  output logic [7:0]                  eng_reg_addr,
  output logic [7:0]                  eng_wr_byte,
  output logic                        eng_abort,
  input  logic                        eng_rsp_valid,
  input  logic                        eng_rsp_nack,
  input  logic [7:0]                  eng_rsp_data,
  output logic                        irq
);

  logic [5:0]          sel;
  logic                addr_unused;
  logic [23:0]         cmd_q, cmd_d;
  logic [31:0]         scratch_q, scratch_d;
  logic [TimeoutW-1:0] timeout_q, timeout_d;
  logic                done_q, done_d, nack_q, nack_d;
  logic                tmo_q, tmo_d, ovr_q, ovr_d;
  logic [7:0]          rd_byte_q, rd_byte_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                busy, start, abort, w1c;
  logic                rsp_done, timeout_set, overrun_set;

  assign sel         = addr[7:2];
  assign addr_unused = ^{addr[AXI_ADDR_WIDTH-1:8], addr[1:0]};

  assign start = wr_en && (sel == RegCtrl) && wstrb[0] && wdata[CtrlStartBit];
  assign abort = wr_en && (sel == RegCtrl) && wstrb[0] && wdata[CtrlAbortBit];
  assign w1c   = wr_en && (sel == RegStatus) && wstrb[0];

  always_comb begin
    cmd_d     = cmd_q;
    scratch_d = scratch_q;
    timeout_d = timeout_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wstrb[i]) begin
        // The command must stay stable for the engine while a transaction is in flight.
        if (sel == RegCmd && !busy && i < 3) cmd_d[8*i +: 8] = wdata[8*i +: 8];
        if (sel == RegTimeout && i < 3)      timeout_d[8*i +: 8] = wdata[8*i +: 8];
        if (sel == RegScratch)               scratch_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Hardware set is applied after the W1C clear so it wins on a collision.
  always_comb begin
    done_d    = done_q;
    nack_d    = nack_q;
    tmo_d     = tmo_q;
    ovr_d     = ovr_q;
    rd_byte_d = rd_byte_q;
    if (w1c && wdata[StatusDoneBit])    done_d = 1'b0;
    if (w1c && wdata[StatusNackBit])    nack_d = 1'b0;
    if (w1c && wdata[StatusTimeoutBit]) tmo_d  = 1'b0;
    if (w1c && wdata[StatusOverrunBit]) ovr_d  = 1'b0;
    if (rsp_done) begin
      done_d = 1'b1;
      nack_d = eng_rsp_nack;
      if (cmd_q[7] && !eng_rsp_nack) rd_byte_d = eng_rsp_data;
    end
    if (timeout_set) tmo_d = 1'b1;
    if (overrun_set) ovr_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    case (sel)
      RegVersion: rdata_d = VERSION;
      RegCmd:     rdata_d = {8'h00, cmd_q};
      RegStatus:  rdata_d = {16'h0000, rd_byte_q, 3'b000, ovr_q, tmo_q, nack_q, done_q, busy};
      RegTimeout: rdata_d = {8'h00, timeout_q};
      RegScratch: rdata_d = scratch_q;
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      cmd_q     <= '0;
      scratch_q <= '0;
      timeout_q <= TIMEOUT_DEFAULT;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      rd_byte_q <= '0;
      rdata_q   <= '0;
    end else begin
      cmd_q     <= cmd_d;
      scratch_q <= scratch_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      rd_byte_q <= rd_byte_d;
      rdata_q   <= rdata_d;
    end
  end

  qsfp_i2c_cmd_fsm u_cmd_fsm (
    .clk_i           (s_axi_aclk),
    .rst_i           (s_axi_areset),
    .start_i         (start),
    .abort_i         (abort),
    .timeout_i       (timeout_q),
    .eng_cmd_ready_i (eng_cmd_ready),
    .eng_rsp_valid_i (eng_rsp_valid),
    .busy_o          (busy),
    .eng_cmd_valid_o (eng_cmd_valid),
    .eng_abort_o     (eng_abort),
    .rsp_done_o      (rsp_done),
    .timeout_set_o   (timeout_set),
    .overrun_set_o   (overrun_set)
  );

  assign rdata        = rdata_q;
  assign eng_dev_addr = cmd_q[6:0];
  assign eng_rnw      = cmd_q[7];
  assign eng_reg_addr = cmd_q[15:8];
  assign eng_wr_byte  = cmd_q[23:16];
  assign irq          = done_q | nack_q | tmo_q | ovr_q;

endmodule

// File: tb/tb_qsfp_i2c_reg_bank.sv
// Directed bench for qsfp_i2c_reg_bank with hand-computed expectations.
module tb_qsfp_i2c_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        eng_cmd_valid, eng_cmd_ready;
  logic [6:0]  eng_dev_addr;
  logic        eng_rnw;
  logic [7:0]  eng_reg_addr, eng_wr_byte;
  logic        eng_abort, eng_rsp_valid, eng_rsp_nack;
  logic [7:0]  eng_rsp_data;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qsfp_i2c_reg_bank dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .wr_en         (wr_en),
    .addr          (addr),
    .wdata         (wdata),
    .wstrb         (wstrb),
    .rdata         (rdata),
    .eng_cmd_valid (eng_cmd_valid),
    .eng_cmd_ready (eng_cmd_ready),
    .eng_dev_addr  (eng_dev_addr),
    .eng_rnw       (eng_rnw),
    .eng_reg_addr  (eng_reg_addr),
    .eng_wr_byte   (eng_wr_byte),
    .eng_abort     (eng_abort),
    .eng_rsp_valid (eng_rsp_valid),
    .eng_rsp_nack  (eng_rsp_nack),
    .eng_rsp_data  (eng_rsp_data),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = s;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    cyc(1);
    d = rdata;
  endtask

  task automatic accept_after(input int n);
    cyc(n);
    eng_cmd_ready = 1'b1;
    cyc(1);
    eng_cmd_ready = 1'b0;
  endtask

  task automatic respond(input logic nack, input logic [7:0] data);
    eng_rsp_valid = 1'b1;
    eng_rsp_nack  = nack;
    eng_rsp_data  = data;
    cyc(1);
    eng_rsp_valid = 1'b0;
    eng_rsp_nack  = 1'b0;
    eng_rsp_data  = 8'h00;
  endtask

  initial begin
    logic [31:0] v;
    int          first_k;
    int          abort_cnt;
    rst = 1'b1;
    wr_en = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    eng_cmd_ready = 1'b0; eng_rsp_valid = 1'b0; eng_rsp_nack = 1'b0; eng_rsp_data = '0;
    cyc(2);
    check("rst_rdata", rdata, 32'h0);
    check("rst_cmd_valid", {31'h0, eng_cmd_valid}, 32'h0);
    check("rst_abort", {31'h0, eng_abort}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    cyc(1);

    rd(32'h00, v); check("version", v, 32'h0001_0000);
    rd(32'h10, v); check("timeout_default", v, 32'h000F_4240);
    rd(32'h0C, v); check("status_reset", v, 32'h0);

    // Write transaction, engine ready three cycles after launch
    wr(32'h04, 32'h00A5_1050, 4'hF);
    rd(32'h04, v); check("cmd_readback", v, 32'h00A5_1050);
    check("eng_fields", {eng_wr_byte, eng_reg_addr, eng_rnw, eng_dev_addr}, 32'h00A5_1050);
    wr(32'h08, 32'h1, 4'hF);
    check("cmd_valid_launch", {31'h0, eng_cmd_valid}, 32'h1);
    accept_after(2);
    check("cmd_valid_after_accept", {31'h0, eng_cmd_valid}, 32'h0);
    respond(1'b0, 8'h3C);
    rd(32'h0C, v); check("status_write_done", v, 32'h0000_0002);
    check("irq_done", {31'h0, irq}, 32'h1);

    // Read transaction
    wr(32'h04, 32'h00A5_10D0, 4'hF);
    check("eng_rnw", {31'h0, eng_rnw}, 32'h1);
    wr(32'h08, 32'h1, 4'hF);
    accept_after(1);
    respond(1'b0, 8'h7E);
    rd(32'h0C, v); check("status_read_done", v, 32'h0000_7E02);
    wr(32'h0C, 32'h2, 4'hF);
    rd(32'h0C, v); check("status_w1c_done", v, 32'h0000_7E00);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // Timeout while engine never ready
    wr(32'h10, 32'd16, 4'hF);
    rd(32'h10, v); check("timeout_rw", v, 32'd16);
    wr(32'h08, 32'h1, 4'hF);
    check("cmd_valid_tmo", {31'h0, eng_cmd_valid}, 32'h1);
    first_k = 0;
    abort_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (eng_abort) begin
        abort_cnt++;
        if (first_k == 0) first_k = k;
      end
    end
    check("abort_cycle", first_k, 32'd16);
    check("abort_pulse_count", abort_cnt, 32'd1);
    check("cmd_valid_after_tmo", {31'h0, eng_cmd_valid}, 32'h0);
    rd(32'h0C, v); check("status_timeout", v, 32'h0000_7E08);
    check("irq_timeout", {31'h0, irq}, 32'h1);
    wr(32'h10, 32'h0, 4'hF);
    wr(32'h0C, 32'h8, 4'hF);

    // Overrun, dropped CMD write, then software abort
    wr(32'h08, 32'h1, 4'hF);
    accept_after(1);
    wr(32'h08, 32'h1, 4'hF);
    check("no_second_valid", {31'h0, eng_cmd_valid}, 32'h0);
    wr(32'h04, 32'h0, 4'hF);
    rd(32'h0C, v); check("status_overrun_busy", v, 32'h0000_7E11);
    rd(32'h04, v); check("cmd_write_dropped", v, 32'h00A5_10D0);
    wr(32'h08, 32'h2, 4'hF);
    check("abort_pulse", {31'h0, eng_abort}, 32'h1);
    cyc(1);
    check("abort_one_cycle", {31'h0, eng_abort}, 32'h0);
    rd(32'h0C, v); check("status_after_abort", v, 32'h0000_7E10);
    wr(32'h0C, 32'h10, 4'hF);
    rd(32'h0C, v); check("status_w1c_overrun", v, 32'h0000_7E00);

    // START+ABORT together in IDLE, and a stray response in IDLE
    wr(32'h08, 32'h3, 4'hF);
    check("start_abort_no_launch", {30'h0, eng_cmd_valid, eng_abort}, 32'h0);
    respond(1'b1, 8'h11);
    rd(32'h0C, v); check("stray_rsp_ignored", v, 32'h0000_7E00);

    // Byte strobes and unmapped space
    wr(32'h14, 32'hFFFF_FFFF, 4'b0010);
    rd(32'h14, v); check("scratch_wstrb", v, 32'h0000_FF00);
    rd(32'h08, v); check("ctrl_reads_zero", v, 32'h0);
    rd(32'h18, v); check("unmapped_zero", v, 32'h0);

    // Asynchronous reset while waiting for the response
    wr(32'h08, 32'h1, 4'hF);
    accept_after(1);
    rd(32'h0C, v); check("busy_in_wait", v, 32'h0000_7E01);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_cmd_valid", {31'h0, eng_cmd_valid}, 32'h0);
    check("rst_mid_abort", {31'h0, eng_abort}, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    cyc(1);
    rst = 1'b0;
    rd(32'h0C, v); check("status_after_rst", v, 32'h0);
    rd(32'h10, v); check("timeout_after_rst", v, 32'h000F_4240);
    respond(1'b0, 8'h55);
    rd(32'h0C, v); check("idle_after_rst", v, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
